feature_out_wr_serializer: RTL and testbench

Read-side counterpart of the feature output register matrix. On a write request it walks the output-channel groups and selects one group's block through `grp_idx_o`. It slices that MS*(2US*2US)*FW-bit block into DW-bit beats and streams them to the DDR write path with a valid/ready handshake. When every requested group has been accepted it pulses `wr_done_o`, which releases the matrix for the next accumulation pass.

---
 rtl/feature_out_wr_serializer.sv | 126 ++++++++++++
 tb/tb_feature_out_wr_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_out_wr_serializer.sv
// Feature output write serializer: walks output-channel groups and streams
// each group block to the DDR write path as DW-bit beats (valid/ready).
module feature_out_wr_serializer #(
    parameter int FW = 32,
    parameter int US = 7,
    parameter int MS = 32,
    parameter int DW = 512,
    parameter int GN = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          start_i,
    input  logic [$clog2(GN+1)-1:0]       grp_num_i,
    output logic [$clog2(GN)-1:0]         grp_idx_o,
    input  logic [MS*4*US*US*FW-1:0]      feat_data_i,
    output logic                          wr_en_o,
    output logic                          ddr_valid_o,
    input  logic                          ddr_rdy_i,
    output logic [DW-1:0]                 ddr_data_o,
    output logic                          ddr_last_o,
    output logic                          busy_o,
    output logic                          wr_done_o
);

    localparam int BW    = MS*4*US*US*FW;
    localparam int BEATS = BW/DW;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int GNW   = $clog2(GN+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic [GNW-1:0]             r_grp_tot;
    logic [CW-1:0]              r_beat_cnt;

    logic [BEATS-1:0][DW-1:0]   w_beats;
    logic [GNW-1:0]             w_grp_num_sat;
    logic [CW-1:0]              w_beat_nxt;
    logic                       w_hs;
    logic                       w_last_beat;
    logic                       w_last_grp;

    // Beat k of the block is simply the k-th DW-bit slice, lowest first.
    assign w_beats       = feat_data_i;
    assign w_grp_num_sat = (grp_num_i > GNW'(GN)) ? GNW'(GN) : grp_num_i;
    assign w_beat_nxt    = r_beat_cnt + CW'(1);
    assign w_hs          = ddr_valid_o && ddr_rdy_i;
    assign w_last_beat   = (r_beat_cnt == CW'(BEATS-1));
    assign w_last_grp    = (GNW'(grp_idx_o) == r_grp_tot - GNW'(1));

    // Control FSM with all outputs registered; next beat loads on the
    // handshake edge so a continuously ready sink sees one beat per cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_grp_tot   <= '0;
            r_beat_cnt  <= '0;
            grp_idx_o   <= '0;
            wr_en_o     <= 1'b0;
            ddr_valid_o <= 1'b0;
            ddr_data_o  <= '0;
            ddr_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            wr_done_o   <= 1'b0;
        end else begin
            wr_done_o <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_grp_tot  <= w_grp_num_sat;
                        grp_idx_o  <= '0;
                        r_beat_cnt <= '0;
                        busy_o     <= 1'b1;
                        if (w_grp_num_sat == '0) begin
                            r_state   <= S_DONE;
                            wr_done_o <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            wr_en_o <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    ddr_data_o  <= w_beats[0];
                    ddr_last_o  <= (BEATS == 1);
                    ddr_valid_o <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (!w_last_beat) begin
                            r_beat_cnt <= w_beat_nxt;
                            ddr_data_o <= w_beats[w_beat_nxt];
                            ddr_last_o <= (w_beat_nxt == CW'(BEATS-1));
                        end else begin
                            ddr_valid_o <= 1'b0;
                            ddr_last_o  <= 1'b0;
                            r_beat_cnt  <= '0;
                            if (w_last_grp) begin
                                wr_en_o   <= 1'b0;
                                wr_done_o <= 1'b1;
                                r_state   <= S_DONE;
                            end else begin
                                grp_idx_o <= grp_idx_o + 1'b1;
                                r_state   <= S_LOAD;
                            end
                        end
                    end
                end
                S_DONE: begin
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_out_wr_serializer.sv
// Bench for feature_out_wr_serializer: matrix model driven by grp_idx_o,
// beat-level reference model, and per-cycle handshake checker.
module tb_feature_out_wr_serializer;

    localparam int FW    = 32;
    localparam int US    = 7;
    localparam int MS    = 32;
    localparam int DW    = 512;
    localparam int GN    = 16;
    localparam int BW    = MS*4*US*US*FW;
    localparam int WPB   = DW/FW;
    localparam int BEATS = BW/DW;
    localparam int NW    = BW/FW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          rdy = 1'b0;
    logic [4:0]    grp_num = '0;
    logic [3:0]    grp_idx;
    logic [BW-1:0] feat;
    logic          wr_en, valid, last, busy, done;
    logic [DW-1:0] data;

    always #5 clk = ~clk;

    feature_out_wr_serializer #(
        .FW(FW), .US(US), .MS(MS), .DW(DW), .GN(GN)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start),
        .grp_num_i   (grp_num),
        .grp_idx_o   (grp_idx),
        .feat_data_i (feat),
        .wr_en_o     (wr_en),
        .ddr_valid_o (valid),
        .ddr_rdy_i   (rdy),
        .ddr_data_o  (data),
        .ddr_last_o  (last),
        .busy_o      (busy),
        .wr_done_o   (done)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Matrix model: word j of group g holds g*65536 + j.
    always_comb begin
        for (int j = 0; j < NW; j++)
            feat[j*FW +: FW] = FW'(int'(grp_idx) * 65536 + j);
    end

    always @(posedge clk) cyc++;

    bit rnd_mode = 1'b0;
    int stalls = 0;
    always @(posedge clk) begin
        #1;
        if (rnd_mode) rdy = 1'($urandom_range(0, 1));
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_beat(int g, int k);
        logic [DW-1:0] b;
        for (int w = 0; w < WPB; w++)
            b[w*FW +: FW] = FW'(g * 65536 + k * WPB + w);
        return b;
    endfunction

    // Reference model state.
    int m_g, m_k, t0, hs_cnt, done_cnt, done_cyc, valid_cyc, wren_cyc;
    bit timed;
    logic [DW-1:0] prev_data, pin_first, pin_lastb, pin_g2;
    logic prev_last, prev_stall, prev_done;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (valid) valid_cyc++;
            if (wr_en) wren_cyc++;
            if (valid) chk("wr_en_with_valid", 64'(wr_en), 1);
            if (valid && prev_stall) begin
                chkw("hold_data", data, prev_data);
                chk("hold_last", 64'(last), 64'(prev_last));
            end
            if (valid && !rdy) stalls++;
            if (valid && rdy) begin
                chkw("beat_data", data, exp_beat(m_g, m_k));
                chk("beat_last", 64'(last), 64'(m_k == BEATS-1));
                chk("grp_idx", 64'(grp_idx), 64'(m_g));
                if (timed)
                    chk("beat_cycle", 64'(cyc),
                        64'(t0 + 2 + m_g*(BEATS+1) + m_k));
                if (m_g == 0 && m_k == 0) pin_first = data;
                if (m_g == 0 && m_k == BEATS-1) pin_lastb = data;
                if (m_g == 2 && m_k == 0) pin_g2 = data;
                hs_cnt++;
                if (m_k == BEATS-1) begin
                    m_k = 0;
                    m_g++;
                end else begin
                    m_k++;
                end
            end
            if (prev_done) begin
                chk("done_one_cycle", 64'(done), 0);
                chk("busy_fall", 64'(busy), 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy), 1);
            end
            prev_stall = valid && !rdy;
            prev_data  = data;
            prev_last  = last;
            prev_done  = done;
        end
    end

    task automatic start_run(int n_in, bit tm);
        @(posedge clk); #1;
        m_g = 0; m_k = 0; hs_cnt = 0; done_cnt = 0;
        valid_cyc = 0; wren_cyc = 0; stalls = 0;
        timed = tm; t0 = cyc;
        grp_num = 5'(n_in);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(string nm, int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        chk({nm, "_done_seen"}, 64'(done_cnt > 0), 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_beats(int n, int budget);
        for (int i = 0; i < budget && hs_cnt < n; i++) @(posedge clk);
        chk("beat_reached", 64'(hs_cnt >= n), 1);
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_grp_idx"}, 64'(grp_idx), 0);
        chk({nm, "_wr_en"}, 64'(wr_en), 0);
        chk({nm, "_valid"}, 64'(valid), 0);
        chkw({nm, "_data"}, data, '0);
        chk({nm, "_last"}, 64'(last), 0);
        chk({nm, "_busy"}, 64'(busy), 0);
        chk({nm, "_done"}, 64'(done), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstn = 1'b1;
        rdy = 1'b1;
        repeat (2) @(posedge clk);

        // Single group, no backpressure.
        start_run(1, 1'b1);
        chk("s1_load_wr_en", 64'(wr_en), 1);
        chk("s1_load_busy", 64'(busy), 1);
        chk("s1_load_valid", 64'(valid), 0);
        wait_done("s1", 2000);
        chk("s1_beats", 64'(hs_cnt), 392);
        chk("s1_done_cnt", 64'(done_cnt), 1);
        chk("s1_done_cyc", 64'(done_cyc), 64'(t0 + 394));
        chk("s1_pin_w0", 64'(pin_first[FW-1:0]), 0);
        chk("s1_pin_w1", 64'(pin_first[2*FW-1:FW]), 1);
        chk("s1_pin_last_w15", 64'(pin_lastb[DW-1 -: FW]), 6271);
        chk("s1_idle_wr_en", 64'(wr_en), 0);

        // Three groups.
        start_run(3, 1'b1);
        wait_done("s2", 3000);
        chk("s2_beats", 64'(hs_cnt), 1176);
        chk("s2_done_cnt", 64'(done_cnt), 1);
        chk("s2_done_cyc", 64'(done_cyc), 64'(t0 + 1180));
        chk("s2_valid_cycles", 64'(valid_cyc), 1176);
        chk("s2_pin_g2_w0", 64'(pin_g2[FW-1:0]), 64'h20000);

        // Random backpressure.
        rnd_mode = 1'b1;
        start_run(1, 1'b0);
        wait_done("s3", 6000);
        rnd_mode = 1'b0;
        rdy = 1'b1;
        chk("s3_beats", 64'(hs_cnt), 392);
        chk("s3_done_cnt", 64'(done_cnt), 1);
        chk("s3_stalls_seen", 64'(stalls > 0), 1);
        chk("s3_pin_last_w15", 64'(pin_lastb[DW-1 -: FW]), 6271);

        // Zero groups.
        start_run(0, 1'b0);
        wait_done("s4", 50);
        chk("s4_done_cyc", 64'(done_cyc), 64'(t0 + 1));
        chk("s4_valid_cycles", 64'(valid_cyc), 0);
        chk("s4_wren_cycles", 64'(wren_cyc), 0);
        chk("s4_done_cnt", 64'(done_cnt), 1);

        // Start during busy.
        start_run(1, 1'b1);
        wait_beats(100, 1000);
        @(posedge clk); #1;
        grp_num = 5'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("s5", 2000);
        chk("s5_beats", 64'(hs_cnt), 392);
        chk("s5_done_cnt", 64'(done_cnt), 1);
        chk("s5_done_cyc", 64'(done_cyc), 64'(t0 + 394));
        repeat (400) @(posedge clk);
        chk("s5_no_restart", 64'(hs_cnt), 392);

        // Reset mid-transfer.
        start_run(1, 1'b0);
        wait_beats(200, 1000);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (3) @(posedge clk);
        chk("midrst_no_done", 64'(done_cnt), 0);
        #1;
        rstn = 1'b1;
        start_run(1, 1'b1);
        wait_done("s6", 2000);
        chk("s6_beats", 64'(hs_cnt), 392);
        chk("s6_done_cyc", 64'(done_cyc), 64'(t0 + 394));
        chk("s6_pin_w0", 64'(pin_first[FW-1:0]), 0);

        // Group count above GN saturates to GN.
        start_run(31, 1'b1);
        wait_done("s7", 8000);
        chk("s7_beats", 64'(hs_cnt), 64'(16 * 392));
        chk("s7_done_cyc", 64'(done_cyc), 64'(t0 + 16*393 + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
